// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the program/data RAM controller:
//   - FSM state encoding (enum type plus legacy-compatible logic constants)
//   - RD_LAT_MAX : largest supported RAM read latency
//   - CNT_W      : width of the read-latency wait counter
// Used by mem_ctrl and mem_ctrl_ibuf (the latter only when MEM_CTRL_IBUF_EN
// is defined).
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

   localparam int RD_LAT_MAX = 4;
   // The counter is loaded with RD_LAT-1, so values 0..RD_LAT_MAX-1 must fit.
   localparam int CNT_W      = $clog2(RD_LAT_MAX);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_RD_WAIT = 2'd2,
      S_RESP    = 2'd3
   } state_e;

   localparam logic [1:0] ST_IDLE    = S_IDLE;
   localparam logic [1:0] ST_ISSUE   = S_ISSUE;
   localparam logic [1:0] ST_RD_WAIT = S_RD_WAIT;
   localparam logic [1:0] ST_RESP    = S_RESP;

endpackage

// File: rtl/mem_ctrl_ibuf.sv
// -----------------------------------------------------------------------------
// mem_ctrl_ibuf
// One-entry instruction buffer (tag, word, valid) used by mem_ctrl when
// MEM_CTRL_IBUF_EN is defined.
// Ports:
//   clk, rst         clock, synchronous active-high reset (clears valid only)
//   fill_i           write fill_tag_i/fill_word_i and mark the entry valid
//   fill_tag_i       address of the completed fetch
//   fill_word_i      word returned by the completed fetch
//   inv_i            a store is being issued to inv_addr_i
//   inv_addr_i       store address; matching the tag invalidates the entry
//   lookup_addr_i    fetch address to compare against the tag
//   hit_o            entry valid and tag equals lookup_addr_i (combinational)
//   word_o           buffered instruction word
// -----------------------------------------------------------------------------
module mem_ctrl_ibuf
   import mem_ctrl_pkg::*;
#(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fill_i,
   input  logic [AWIDTH-1:0] fill_tag_i,
   input  logic [DWIDTH-1:0] fill_word_i,
   input  logic              inv_i,
   input  logic [AWIDTH-1:0] inv_addr_i,
   input  logic [AWIDTH-1:0] lookup_addr_i,
   output logic              hit_o,
   output logic [DWIDTH-1:0] word_o
);

   logic              valid_q, valid_d;
   logic [AWIDTH-1:0] tag_q;
   logic [DWIDTH-1:0] word_q;

   always_comb begin
      valid_d = valid_q;
      if (inv_i && (inv_addr_i == tag_q)) begin
         valid_d = 1'b0;
      end else if (fill_i) begin
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Payload needs no reset: it is only observed through a valid hit.
   always_ff @(posedge clk) begin
      if (fill_i) begin
         tag_q  <= fill_tag_i;
         word_q <= fill_word_i;
      end
   end

   assign hit_o  = valid_q && (lookup_addr_i == tag_q);
   assign word_o = word_q;

endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Arbitrates instruction fetches and data loads/stores onto one single-port
// synchronous RAM and returns read words on a shared registered bus.
// Optional feature macro: MEM_CTRL_IBUF_EN adds a one-entry instruction
// buffer; fetches hitting it complete without a RAM access.
// Parameters: DWIDTH word width, AWIDTH address width, RD_LAT RAM read
// latency (1..RD_LAT_MAX).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   en_fetch, pc_addr         fetch request pulse and address
//   ram_en, wen, ram_addr,
//   wdata                     data request pulse, store flag, address, data
//   ins                       last read word, held until the next read
//   en_ram_out                one-cycle pulse: fetch completed
//   ram_valid                 one-cycle pulse: load or store completed
//   busy                      access in progress or request pending
//   err                       sticky: a request hit a full slot and was dropped
//   mem_cs, mem_we,
//   mem_addr, mem_wdata       registered RAM command, nonzero only in ISSUE
//   mem_rdata                 RAM read data
// -----------------------------------------------------------------------------
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 16,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_fetch,
   input  logic [AWIDTH-1:0] pc_addr,
   input  logic              ram_en,
   input  logic              wen,
   input  logic [AWIDTH-1:0] ram_addr,
   input  logic [DWIDTH-1:0] wdata,
   output logic [DWIDTH-1:0] ins,
   output logic              en_ram_out,
   output logic              ram_valid,
   output logic              busy,
   output logic              err,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata
);

   // Control state
   logic [1:0]        state_q, state_d;
   logic              sel_fetch_q, sel_fetch_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              fvld_q, fvld_d;
   logic              dvld_q, dvld_d;
   logic [DWIDTH-1:0] ins_q, ins_d;
   logic              mem_cs_q, mem_cs_d;
   logic              mem_we_q, mem_we_d;
   logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;

   // Pending-slot payloads
   logic              fetch_ld, data_ld;
   logic [AWIDTH-1:0] faddr_q;
   logic              dwe_q;
   logic [AWIDTH-1:0] daddr_q;
   logic [DWIDTH-1:0] dwdata_q;

`ifdef MEM_CTRL_IBUF_EN
   logic              hit_pend_q, hit_pend_d;
   logic              ibuf_hit;
   logic [DWIDTH-1:0] ibuf_word;
   logic              ibuf_fill;
   logic [AWIDTH-1:0] fetch_addr_q;

   mem_ctrl_ibuf #(
      .DWIDTH(DWIDTH),
      .AWIDTH(AWIDTH)
   ) u_ibuf (
      .clk          (clk),
      .rst          (rst),
      .fill_i       (ibuf_fill),
      .fill_tag_i   (fetch_addr_q),
      .fill_word_i  (mem_rdata),
      .inv_i        ((state_q == ST_ISSUE) && mem_we_q),
      .inv_addr_i   (mem_addr_q),
      .lookup_addr_i(faddr_q),
      .hit_o        (ibuf_hit),
      .word_o       (ibuf_word)
   );
`endif

   always_comb begin
      state_d     = state_q;
      sel_fetch_d = sel_fetch_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      fvld_d      = fvld_q;
      dvld_d      = dvld_q;
      ins_d       = ins_q;
      fetch_ld    = 1'b0;
      data_ld     = 1'b0;
      // RAM command is a one-cycle pulse: zero unless leaving IDLE to ISSUE.
      mem_cs_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
`ifdef MEM_CTRL_IBUF_EN
      hit_pend_d  = hit_pend_q;
      ibuf_fill   = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
`ifdef MEM_CTRL_IBUF_EN
            // A buffer hit spends one lookup cycle in IDLE, then goes
            // straight to RESP with the buffered word.
            if (hit_pend_q) begin
               hit_pend_d  = 1'b0;
               ins_d       = ibuf_word;
               sel_fetch_d = 1'b1;
               state_d     = ST_RESP;
            end else if (fvld_q && ibuf_hit) begin
               hit_pend_d  = 1'b1;
               fvld_d      = 1'b0;
            end else
`endif
            if (fvld_q) begin
               sel_fetch_d = 1'b1;
               mem_cs_d    = 1'b1;
               mem_addr_d  = faddr_q;
               state_d     = ST_ISSUE;
            end else if (dvld_q) begin
               sel_fetch_d = 1'b0;
               mem_cs_d    = 1'b1;
               mem_we_d    = dwe_q;
               mem_addr_d  = daddr_q;
               mem_wdata_d = dwdata_q;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Slot stays occupied through ISSUE, so a new request for it
            // arriving here is still dropped.
            if (sel_fetch_q) fvld_d = 1'b0;
            else             dvld_d = 1'b0;
            if (mem_we_q) begin
               state_d = ST_RESP;
            end else begin
               cnt_d   = CNT_W'(RD_LAT - 1);
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (cnt_q == '0) begin
               ins_d   = mem_rdata;
               state_d = ST_RESP;
`ifdef MEM_CTRL_IBUF_EN
               ibuf_fill = sel_fetch_q;
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Request intake: a full slot keeps its contents and flags the loss.
      if (en_fetch) begin
         if (fvld_q) begin
            err_d = 1'b1;
         end else begin
            fvld_d   = 1'b1;
            fetch_ld = 1'b1;
         end
      end
      if (ram_en) begin
         if (dvld_q) begin
            err_d = 1'b1;
         end else begin
            dvld_d  = 1'b1;
            data_ld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sel_fetch_q <= 1'b0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         fvld_q      <= 1'b0;
         dvld_q      <= 1'b0;
         ins_q       <= '0;
         mem_cs_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
`ifdef MEM_CTRL_IBUF_EN
         hit_pend_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sel_fetch_q <= sel_fetch_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         fvld_q      <= fvld_d;
         dvld_q      <= dvld_d;
         ins_q       <= ins_d;
         mem_cs_q    <= mem_cs_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
`ifdef MEM_CTRL_IBUF_EN
         hit_pend_q  <= hit_pend_d;
`endif
      end
   end

   // Slot payloads are qualified by the valid bits and need no reset.
   always_ff @(posedge clk) begin
      if (fetch_ld) begin
         faddr_q <= pc_addr;
      end
      if (data_ld) begin
         dwe_q    <= wen;
         daddr_q  <= ram_addr;
         dwdata_q <= wdata;
      end
`ifdef MEM_CTRL_IBUF_EN
      // Remembers the address of the fetch being issued for the buffer fill.
      if (state_q == ST_IDLE) begin
         fetch_addr_q <= faddr_q;
      end
`endif
   end

   assign ins        = ins_q;
   assign en_ram_out = (state_q == ST_RESP) &&  sel_fetch_q;
   assign ram_valid  = (state_q == ST_RESP) && !sel_fetch_q;
`ifdef MEM_CTRL_IBUF_EN
   assign busy       = (state_q != ST_IDLE) || fvld_q || dvld_q || hit_pend_q;
`else
   assign busy       = (state_q != ST_IDLE) || fvld_q || dvld_q;
`endif
   assign err        = err_q;
   assign mem_cs     = mem_cs_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Two controllers share one stimulus: u_dut1 with RD_LAT=1 and u_dut4 with
// RD_LAT=4, each with its own read pipeline over a shared RAM array.
// Cycle numbering: the request is sampled at edge T; observation index n
// refers to cycle T+1+n (sampled 1 time unit after each rising edge).
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_fetch, ram_en, wen;
   logic [15:0] pc_addr, ram_addr, wdata;

   logic [15:0] ins1, mem_addr1, mem_wdata1, mem_rdata1;
   logic        en_ram_out1, ram_valid1, busy1, err1, mem_cs1, mem_we1;
   logic [15:0] ins4, mem_addr4, mem_wdata4, mem_rdata4;
   logic        en_ram_out4, ram_valid4, busy4, err4, mem_cs4, mem_we4;

   always #5 clk = ~clk;

   mem_ctrl #(.DWIDTH(16), .AWIDTH(16), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .en_fetch(en_fetch), .pc_addr(pc_addr),
      .ram_en(ram_en), .wen(wen), .ram_addr(ram_addr), .wdata(wdata),
      .ins(ins1), .en_ram_out(en_ram_out1), .ram_valid(ram_valid1),
      .busy(busy1), .err(err1), .mem_cs(mem_cs1), .mem_we(mem_we1),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
   );

   mem_ctrl #(.DWIDTH(16), .AWIDTH(16), .RD_LAT(4)) u_dut4 (
      .clk(clk), .rst(rst), .en_fetch(en_fetch), .pc_addr(pc_addr),
      .ram_en(ram_en), .wen(wen), .ram_addr(ram_addr), .wdata(wdata),
      .ins(ins4), .en_ram_out(en_ram_out4), .ram_valid(ram_valid4),
      .busy(busy4), .err(err4), .mem_cs(mem_cs4), .mem_we(mem_we4),
      .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4)
   );

   // RAM model. Both controllers see identical stores at identical cycles,
   // so only u_dut1 writes the array.
   logic [15:0] ram [0:65535];
   logic [15:0] pipe1;
   logic [15:0] pipe4 [0:3];

   always @(posedge clk) begin
      if (mem_cs1 && mem_we1)  ram[mem_addr1] <= mem_wdata1;
      if (mem_cs1 && !mem_we1) pipe1 <= ram[mem_addr1];
      if (mem_cs4 && !mem_we4) pipe4[0] <= ram[mem_addr4];
      pipe4[1] <= pipe4[0];
      pipe4[2] <= pipe4[1];
      pipe4[3] <= pipe4[2];
   end
   assign mem_rdata1 = pipe1;
   assign mem_rdata4 = pipe4[3];

   // Scoreboard state
   int n_cmp = 0;
   int n_bad = 0;

   int          f1_at, d1_at, f4_at, d4_at, nf1, nd1, nf4, nd4, ncs1, ncs4;
   logic [15:0] ins_f1, ins_d1, ins_f4, ins_d4, cs1_addr, cs1_wd;
   logic        cs1_we, busy_first, busy_last;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic clr_obs();
      f1_at = -1; d1_at = -1; f4_at = -1; d4_at = -1;
      nf1 = 0; nd1 = 0; nf4 = 0; nd4 = 0; ncs1 = 0; ncs4 = 0;
      ins_f1 = '0; ins_d1 = '0; ins_f4 = '0; ins_d4 = '0;
      cs1_addr = '0; cs1_wd = '0; cs1_we = 1'b0;
      busy_first = 1'b0; busy_last = 1'b0;
   endtask

   // Samples cycles n0..n1-1; the caller is already positioned at cycle n0.
   task automatic observe(input int n0, input int n1);
      for (int n = n0; n < n1; n++) begin
         if (n > n0) begin
            @(posedge clk); #1;
         end
         if (n == n0) busy_first = busy1;
         busy_last = busy1;
         if (mem_cs1) begin
            if (ncs1 == 0) begin
               cs1_addr = mem_addr1; cs1_we = mem_we1; cs1_wd = mem_wdata1;
            end
            ncs1++;
         end
         if (mem_cs4) ncs4++;
         if (en_ram_out1) begin if (nf1 == 0) begin f1_at = n; ins_f1 = ins1; end nf1++; end
         if (ram_valid1)  begin if (nd1 == 0) begin d1_at = n; ins_d1 = ins1; end nd1++; end
         if (en_ram_out4) begin if (nf4 == 0) begin f4_at = n; ins_f4 = ins4; end nf4++; end
         if (ram_valid4)  begin if (nd4 == 0) begin d4_at = n; ins_d4 = ins4; end nd4++; end
      end
   endtask

   typedef struct {
      bit          f;        // 1 = fetch, 0 = data access
      bit          w;        // store when data access
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] exp_ins;  // checked for reads only
      int          lat1;     // strobe index n for RD_LAT=1
      int          lat4;     // strobe index n for RD_LAT=4
      int          ncs;      // RAM selects expected
   } vec_t;

   vec_t vt [9];

   initial begin
      // Table: read latency n = 2+RD_LAT, store n = 2, buffer hit n = 2.
      vt[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1A05, 3, 6, 1};
      vt[1] = '{1'b0, 1'b1, 16'h0020, 16'hBEEF, 16'h0000, 2, 2, 1};
      vt[2] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 3, 6, 1};
      vt[3] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h4444, 3, 6, 1};
      vt[4] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 16'h5555, 3, 6, 1};
      vt[5] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'h3030, 3, 6, 1};
`ifdef MEM_CTRL_IBUF_EN
      vt[6] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'h3030, 2, 2, 0};
`else
      vt[6] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'h3030, 3, 6, 1};
`endif
      vt[7] = '{1'b0, 1'b1, 16'h0030, 16'h5A5A, 16'h0000, 2, 2, 1};
      vt[8] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5A5A, 3, 6, 1};

      for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
      ram[16'h0001] = 16'h1111; ram[16'h0002] = 16'h2222;
      ram[16'h0004] = 16'h4444; ram[16'h0005] = 16'h5555;
      ram[16'h0010] = 16'h1A05; ram[16'h0030] = 16'h3030;
      ram[16'h0040] = 16'h4040; ram[16'h0050] = 16'h5050;

      rst = 1'b1; en_fetch = 1'b0; ram_en = 1'b0; wen = 1'b0;
      pc_addr = '0; ram_addr = '0; wdata = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_dut1", {ins1, en_ram_out1, ram_valid1, busy1, err1, mem_cs1, mem_we1, mem_addr1, mem_wdata1}, 64'd0);
      chk("reset_dut4", {ins4, en_ram_out4, ram_valid4, busy4, err4, mem_cs4, mem_we4, mem_addr4, mem_wdata4}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_dut1", {ins1, en_ram_out1, ram_valid1, busy1, err1, mem_cs1}, 64'd0);

      // Single transactions from the table
      for (int i = 0; i < 9; i++) begin
         clr_obs();
         en_fetch = vt[i].f; ram_en = !vt[i].f; wen = vt[i].w;
         pc_addr = vt[i].a; ram_addr = vt[i].a; wdata = vt[i].d;
         @(posedge clk); #1;
         en_fetch = 1'b0; ram_en = 1'b0; wen = 1'b0;
         observe(0, 14);
         chk($sformatf("v%0d_lat1", i), vt[i].f ? f1_at : d1_at, vt[i].lat1);
         chk($sformatf("v%0d_lat4", i), vt[i].f ? f4_at : d4_at, vt[i].lat4);
         chk($sformatf("v%0d_strobes1", i), {nf1[7:0], nd1[7:0]}, vt[i].f ? 16'h0100 : 16'h0001);
         chk($sformatf("v%0d_strobes4", i), {nf4[7:0], nd4[7:0]}, vt[i].f ? 16'h0100 : 16'h0001);
         chk($sformatf("v%0d_ncs1", i), ncs1, vt[i].ncs);
         chk($sformatf("v%0d_ncs4", i), ncs4, vt[i].ncs);
         if (!vt[i].w) begin
            chk($sformatf("v%0d_ins1", i), vt[i].f ? ins_f1 : ins_d1, vt[i].exp_ins);
            chk($sformatf("v%0d_ins4", i), vt[i].f ? ins_f4 : ins_d4, vt[i].exp_ins);
         end
         if (vt[i].ncs != 0) begin
            chk($sformatf("v%0d_cmd1", i), {cs1_we, cs1_addr, cs1_wd},
                {vt[i].w, vt[i].a, vt[i].w ? vt[i].d : 16'h0000});
         end
         chk($sformatf("v%0d_busy", i), {busy_first, busy_last}, 2'b10);
      end

      // Simultaneous fetch and load: fetch first, data 3+RD_LAT cycles later
      clr_obs();
      en_fetch = 1'b1; pc_addr = 16'h0001;
      ram_en = 1'b1; wen = 1'b0; ram_addr = 16'h0002;
      @(posedge clk); #1;
      en_fetch = 1'b0; ram_en = 1'b0;
      observe(0, 20);
      chk("sim_first_addr1", cs1_addr, 16'h0001);
      chk("sim_fetch_at1", f1_at, 3);
      chk("sim_data_at1", d1_at, 7);
      chk("sim_ins1", {ins_f1, ins_d1}, {16'h1111, 16'h2222});
      chk("sim_ncs1", ncs1, 2);
      chk("sim_fetch_at4", f4_at, 6);
      chk("sim_data_at4", d4_at, 13);
      chk("sim_ins4", {ins_f4, ins_d4}, {16'h1111, 16'h2222});
      chk("sim_err", {err1, err4}, 2'b00);

      // Second fetch while the first is pending is dropped
      clr_obs();
      en_fetch = 1'b1; pc_addr = 16'h0040;
      @(posedge clk); #1;
      pc_addr = 16'h0041;
      @(posedge clk); #1;
      en_fetch = 1'b0;
      observe(1, 14);
      chk("drop_nf1", nf1, 1);
      chk("drop_ins1", ins_f1, 16'h4040);
      chk("drop_at1", f1_at, 3);
      chk("drop_ncs1", ncs1, 1);
      chk("drop_nf4", nf4, 1);
      chk("drop_err", {err1, err4}, 2'b11);
      repeat (5) @(posedge clk);
      #1;
      chk("err_sticky", {err1, err4}, 2'b11);

      // Reset during RD_WAIT of the RD_LAT=4 controller aborts the access
      clr_obs();
      en_fetch = 1'b1; pc_addr = 16'h0050;
      @(posedge clk); #1;
      en_fetch = 1'b0;
      observe(0, 4);
      chk("abort_pre_nf4", nf4, 0);
      chk("abort_pre_ncs4", ncs4, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_zero4", {ins4, en_ram_out4, ram_valid4, busy4, err4, mem_cs4, mem_we4, mem_addr4, mem_wdata4}, 64'd0);
      clr_obs();
      observe(4, 14);
      chk("abort_post_strobes4", {nf4[7:0], nd4[7:0]}, 16'h0000);
      chk("abort_post_ncs4", ncs4, 0);

      // Fresh fetch after the abort completes normally
      clr_obs();
      en_fetch = 1'b1; pc_addr = 16'h0050;
      @(posedge clk); #1;
      en_fetch = 1'b0;
      observe(0, 14);
      chk("refetch_at4", f4_at, 6);
      chk("refetch_ins4", ins_f4, 16'h5050);
      chk("refetch_at1", f1_at, 3);
      chk("refetch_ins1", ins_f1, 16'h5050);
      chk("refetch_ncs1", ncs1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
